simd_result_drain: RTL and testbench



---
 rtl/simd_result_drain.sv | 119 +++++++++++
 tb/tb_simd_result_drain.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_result_drain.sv
// simd_result_drain
// Captures the N x N 32-bit result matrix on each rising edge of OFFSWT and
// streams it out as one AXI4-Stream packet of N*N words, row-major, with
// TLAST on the final word. The PE array is free again once the snapshot is taken.
//
// Ports:
//   CLK, RSTN        clock, synchronous active-low reset
//   OFFSWT           operation-complete level; a rising edge starts a drain
//   MAT_OUT          result matrix, MAT_OUT[r][c], valid when OFFSWT rises
//   M_AXIS_*         AXI4-Stream master (TDATA, TVALID, TREADY, TLAST)
//   BUSY             high from capture until the last beat is accepted
//   DRAIN_DONE       one-cycle pulse after the last handshake
//   OVERRUN          sticky; a completion edge arrived while BUSY

// One snapshot row. It holds N words and selects the word for the current column.
module simd_result_drain_row #(
  parameter int N    = 16,
  parameter int LogN = $clog2(N)
) (
  input  logic                 CLK,
  input  logic                 capture,
  input  logic [N-1:0][31:0]   row_in,
  input  logic [LogN-1:0]      col,
  output logic [31:0]          word
);
  // No reset: data is qualified by TVALID, and TDATA is masked outside STREAM.
  logic [N-1:0][31:0] snap;

  always_ff @(posedge CLK)
    if (capture) snap <= row_in;

  assign word = snap[col];
endmodule

module simd_result_drain #(
  parameter int N    = 16,
  parameter int LogN = $clog2(N)
) (
  input  logic                       CLK,
  input  logic                       RSTN,
  input  logic                       OFFSWT,
  input  logic [N-1:0][N-1:0][31:0]  MAT_OUT,
  output logic [31:0]                M_AXIS_TDATA,
  output logic                       M_AXIS_TVALID,
  input  logic                       M_AXIS_TREADY,
  output logic                       M_AXIS_TLAST,
  output logic                       BUSY,
  output logic                       DRAIN_DONE,
  output logic                       OVERRUN
);
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t               state, state_nxt;
  logic                 prev_off, trig, capture, last_beat, hs;
  logic [LogN-1:0]      row, col;
  logic [N-1:0][31:0]   row_word;

  // prev_off resets high so a level already present at reset exit is not an edge.
  assign trig      = OFFSWT & ~prev_off;
  assign last_beat = (row == LogN'(N-1)) && (col == LogN'(N-1));
  assign hs        = M_AXIS_TVALID & M_AXIS_TREADY;

  for (genvar r = 0; r < N; r++) begin : g_row
    simd_result_drain_row #(.N(N), .LogN(LogN)) u_row (
      .CLK     (CLK),
      .capture (capture),
      .row_in  (MAT_OUT[r]),
      .col     (col),
      .word    (row_word[r])
    );
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE:   if (trig) begin
                capture   = 1'b1;
                state_nxt = STREAM;
              end
      STREAM: if (hs && last_beat) state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state    <= IDLE;
      row      <= '0;
      col      <= '0;
      prev_off <= 1'b1;
      OVERRUN  <= 1'b0;
    end else begin
      state    <= state_nxt;
      prev_off <= OFFSWT;
      // Edges outside IDLE (including the DONE cycle) are dropped and flagged.
      if (trig && state != IDLE) OVERRUN <= 1'b1;
      if (capture) begin
        row <= '0;
        col <= '0;
      end else if (state == STREAM && hs && !last_beat) begin
        if (col == LogN'(N-1)) begin
          col <= '0;
          row <= row + LogN'(1);
        end else begin
          col <= col + LogN'(1);
        end
      end
    end
  end

  // All outputs decode registered state only; nothing depends on TREADY.
  assign M_AXIS_TVALID = (state == STREAM);
  assign M_AXIS_TLAST  = M_AXIS_TVALID & last_beat;
  assign M_AXIS_TDATA  = M_AXIS_TVALID ? row_word[row] : 32'd0;
  assign BUSY          = (state != IDLE);
  assign DRAIN_DONE    = (state == DONE);
endmodule

// File: tb/tb_simd_result_drain.sv
// Bench for simd_result_drain: an N=4 instance (basic, backpressure, snapshot
// isolation, overrun, reset cases) and an N=16 instance (full size, back-to-back).
// Expected words are pushed to a queue when a trigger is driven and are popped
// on every handshake.
module tb_simd_result_drain;
  localparam int NA = 4;
  localparam int NB = 16;
  typedef logic [NA-1:0][NA-1:0][31:0] mat4_t;
  typedef logic [NB-1:0][NB-1:0][31:0] mat16_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn = 1'b0;

  logic        off_a = 1'b0, rdy_a = 1'b1, rnd_a = 1'b0;
  mat4_t       mat_a = '0;
  logic [31:0] tdata_a;
  logic        tvalid_a, tlast_a, busy_a, done_a, ovr_a;

  logic        off_b = 1'b0, rdy_b = 1'b1;
  mat16_t      mat_b = '0;
  logic [31:0] tdata_b;
  logic        tvalid_b, tlast_b, busy_b, done_b, ovr_b;

  simd_result_drain #(.N(NA)) dut_a (
    .CLK(clk), .RSTN(rstn), .OFFSWT(off_a), .MAT_OUT(mat_a),
    .M_AXIS_TDATA(tdata_a), .M_AXIS_TVALID(tvalid_a), .M_AXIS_TREADY(rdy_a),
    .M_AXIS_TLAST(tlast_a), .BUSY(busy_a), .DRAIN_DONE(done_a), .OVERRUN(ovr_a)
  );

  simd_result_drain #(.N(NB)) dut_b (
    .CLK(clk), .RSTN(rstn), .OFFSWT(off_b), .MAT_OUT(mat_b),
    .M_AXIS_TDATA(tdata_b), .M_AXIS_TVALID(tvalid_b), .M_AXIS_TREADY(rdy_b),
    .M_AXIS_TLAST(tlast_b), .BUSY(busy_b), .DRAIN_DONE(done_b), .OVERRUN(ovr_b)
  );

  int checks = 0, errors = 0;
  logic [31:0] sb_a[$], sb_b[$];
  int beats_a = 0, dones_a = 0, busy_cnt_a = 0, dones_b = 0;
  logic [31:0] last_b = '0;
  logic        stall_pend = 1'b0, stall_last = 1'b0;
  logic [31:0] stall_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // TREADY driver: ~50% random when rnd_a is set, otherwise held high.
  always @(posedge clk) begin
    #1;
    rdy_a = rnd_a ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor A: scoreboard pop on handshake, stall stability, pulse/busy counting.
  always @(negedge clk) begin : mon_a
    logic [31:0] e;
    if (rstn) begin
      if (stall_pend) begin
        chk("stall_vld",  32'(tvalid_a), 32'd1);
        chk("stall_data", tdata_a, stall_data);
        chk("stall_last", 32'(tlast_a), 32'(stall_last));
      end
      stall_pend = tvalid_a & ~rdy_a;
      stall_data = tdata_a;
      stall_last = tlast_a;
      if (tvalid_a && rdy_a) begin
        beats_a++;
        if (sb_a.size() == 0) chk("extra_beat_a", 32'(sb_a.size()), 32'd1);
        else begin
          e = sb_a.pop_front();
          chk("tdata_a", tdata_a, e);
          chk("tlast_a", 32'(tlast_a), 32'(sb_a.size() == 0));
        end
      end
      if (done_a) dones_a++;
      if (busy_a) busy_cnt_a++;
    end else stall_pend = 1'b0;
  end

  always @(negedge clk) begin : mon_b
    logic [31:0] e;
    if (rstn) begin
      if (tvalid_b && rdy_b) begin
        if (sb_b.size() == 0) chk("extra_beat_b", 32'(sb_b.size()), 32'd1);
        else begin
          e = sb_b.pop_front();
          chk("tdata_b", tdata_b, e);
          chk("tlast_b", 32'(tlast_b), 32'(sb_b.size() == 0));
        end
        if (tlast_b) last_b = tdata_b;
      end
      if (done_b) dones_b++;
    end
  end

  function automatic mat4_t pat_a(input logic [31:0] base, input bit rnd);
    mat4_t m;
    for (int r = 0; r < NA; r++)
      for (int c = 0; c < NA; c++)
        m[r][c] = rnd ? $urandom : base + 32'(16 * r + c);
    return m;
  endfunction

  // Called just after a posedge: raise OFFSWT for one cycle and queue the words.
  task automatic trig_a(input mat4_t m);
    mat_a = m;
    off_a = 1'b1;
    for (int r = 0; r < NA; r++)
      for (int c = 0; c < NA; c++) sb_a.push_back(m[r][c]);
    @(posedge clk); #1;
    off_a = 1'b0;
  endtask

  task automatic trig_b(input mat16_t m);
    mat_b = m;
    off_b = 1'b1;
    for (int r = 0; r < NB; r++)
      for (int c = 0; c < NB; c++) sb_b.push_back(m[r][c]);
    @(posedge clk); #1;
    off_b = 1'b0;
  endtask

  task automatic drain_a();
    int n = 0;
    do begin @(negedge clk); n++; end while ((busy_a || sb_a.size() != 0) && n < 2000);
    chk("drain_a_in_time", 32'(n < 2000), 32'd1);
  endtask

  task automatic drain_b();
    int n = 0;
    do begin @(negedge clk); n++; end while ((busy_b || sb_b.size() != 0) && n < 2000);
    chk("drain_b_in_time", 32'(n < 2000), 32'd1);
  endtask

  task automatic wait_beats_a(input int k);
    int n = 0;
    while (beats_a < k && n < 200) begin @(posedge clk); n++; end
    chk("beat_wait_in_time", 32'(n < 200), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    mat4_t m;
    mat16_t mb;
    int n;

    // Reset state
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("rst_tvalid", 32'(tvalid_a), 32'd0);
    chk("rst_tlast",  32'(tlast_a),  32'd0);
    chk("rst_busy",   32'(busy_a),   32'd0);
    chk("rst_done",   32'(done_a),   32'd0);
    chk("rst_ovr",    32'(ovr_a),    32'd0);
    chk("rst_tdata",  tdata_a,       32'd0);

    // Basic: 16r+c, TREADY high, first beat one cycle after the trigger edge
    m = pat_a(32'd0, 1'b0);
    @(posedge clk); #1;
    busy_cnt_a = 0; dones_a = 0;
    trig_a(m);
    @(negedge clk);
    chk("lat_tvalid", 32'(tvalid_a), 32'd1);
    chk("lat_busy",   32'(busy_a),   32'd1);
    chk("lat_tdata",  tdata_a,       32'd0);
    drain_a();
    chk("basic_busy_cycles", 32'(busy_cnt_a), 32'd17);
    chk("basic_done_pulses", 32'(dones_a),    32'd1);

    // Backpressure plus snapshot isolation (MAT_OUT forced to all ones after capture)
    m = pat_a(32'd0, 1'b1);
    rnd_a = 1'b1;
    @(posedge clk); #1;
    dones_a = 0;
    trig_a(m);
    mat_a = '1;
    drain_a();
    rnd_a = 1'b0;
    chk("bp_done_pulses", 32'(dones_a), 32'd1);

    // Overrun: second edge during beat 5
    m = pat_a(32'h100, 1'b0);
    @(posedge clk); #1;
    beats_a = 0; dones_a = 0;
    trig_a(m);
    wait_beats_a(5);
    #1 off_a = 1'b1;
    @(posedge clk); #1 off_a = 1'b0;
    drain_a();
    repeat (5) @(negedge clk);
    chk("ovr_set",      32'(ovr_a),   32'd1);
    chk("ovr_no_2nd",   32'(beats_a), 32'd16);
    chk("ovr_tvalid",   32'(tvalid_a), 32'd0);
    chk("ovr_dones",    32'(dones_a), 32'd1);
    do_reset();
    @(negedge clk);
    chk("ovr_clr_rst",  32'(ovr_a),   32'd0);

    // Edge landing in the DONE cycle counts as overrun and starts nothing
    m = pat_a(32'h200, 1'b0);
    @(posedge clk); #1;
    beats_a = 0;
    trig_a(m);
    n = 0;
    do begin @(negedge clk); n++; end while (!done_a && n < 200);
    chk("done_wait_in_time", 32'(n < 200), 32'd1);
    off_a = 1'b1;
    repeat (4) @(negedge clk);
    off_a = 1'b0;
    chk("done_edge_ovr",  32'(ovr_a),   32'd1);
    chk("done_edge_busy", 32'(busy_a),  32'd0);
    chk("done_edge_beats", 32'(beats_a), 32'd16);

    // OFFSWT held high through reset release: no packet
    @(posedge clk); #1 rstn = 1'b0; off_a = 1'b1;
    @(posedge clk); #1 rstn = 1'b1;
    repeat (4) @(negedge clk);
    chk("held_busy",   32'(busy_a),   32'd0);
    chk("held_tvalid", 32'(tvalid_a), 32'd0);
    chk("held_ovr",    32'(ovr_a),    32'd0);
    off_a = 1'b0;

    // Reset at beat 7 aborts; a new trigger restarts from [0][0]
    m = pat_a(32'h300, 1'b0);
    @(posedge clk); #1;
    beats_a = 0;
    trig_a(m);
    wait_beats_a(7);
    #1 rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    sb_a.delete();
    @(negedge clk);
    chk("abort_tvalid", 32'(tvalid_a), 32'd0);
    chk("abort_busy",   32'(busy_a),   32'd0);
    m = pat_a(32'h400, 1'b0);
    @(posedge clk); #1;
    beats_a = 0;
    trig_a(m);
    drain_a();
    chk("restart_beats", 32'(beats_a), 32'd16);

    // Full size N=16, then back-to-back trigger in the first IDLE cycle
    for (int r = 0; r < NB; r++)
      for (int c = 0; c < NB; c++) mb[r][c] = 32'hA000_0000 | 32'(r << 8) | 32'(c);
    @(posedge clk); #1;
    dones_b = 0;
    trig_b(mb);
    n = 0;
    do begin @(negedge clk); n++; end while (!done_b && n < 600);
    chk("b_done_in_time", 32'(n < 600), 32'd1);
    chk("b_last_word", last_b, 32'hA000_0F0F);
    @(posedge clk); #1;
    for (int r = 0; r < NB; r++)
      for (int c = 0; c < NB; c++) mb[r][c] = 32'h5000_0000 | 32'(r << 8) | 32'(c);
    trig_b(mb);
    @(negedge clk);
    chk("b2b_tvalid", 32'(tvalid_b), 32'd1);
    drain_b();
    chk("b2b_ovr",   32'(ovr_b),   32'd0);
    chk("b2b_dones", 32'(dones_b), 32'd2);
    chk("b2b_last",  last_b,       32'h5000_0F0F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
